top_level: RTL and testbench
============================

Name: top_level

Overview:
- Dual-core private L1 data-cache subsystem: two identical direct-mapped, write-through, write-allocate caches, one per CPU port (0 and 1).
- Each cache has its own memory-side request/response channel.
- Coherence between the two caches uses write-invalidate snooping: any write from one core invalidates the matching line in the other core's cache.
- Sits between two CPU cores and an external memory/arbiter of 16-bit-address, byte-data, 2-byte lines.

Parameters:
INDEX_BITS, 4, line-index width per cache (2**INDEX_BITS lines, default 16)
LINE_BYTES, 2, bytes per line (fixed; offset = addr[0])

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_request_0/1  input  25  {we[24], wdata[23:16], addr[15:0]}
cpu_request_ready_0/1  input  1  request valid level, held until data_out_ready seen
memory_response_0/1  input  16  aligned line: [7:0] = byte at addr&~1, [15:8] = byte at addr|1
memory_response_ready_0/1  input  1  memory_response valid
data_out_0/1  output  8  read data, or written byte on writes
data_out_ready_0/1  output  1  request complete
memory_request_0/1  output  25  {we, wdata, addr}, copied from the CPU request
memory_request_ready_0/1  output  1  memory request valid

Behaviour:
- Address split: offset = addr[0]; index = addr[INDEX_BITS:1]; tag = addr[15:INDEX_BITS+1]. Per line: valid bit, tag, 16-bit data.
- Reset (reset low, async):
  - All valid bits clear.
  - FSMs go to IDLE.
  - All outputs are 0, including data_out.
  - A reset mid-transaction aborts the transaction; no memory state is assumed.
- Per-core FSM states: IDLE, LOOKUP, MEM_WAIT, DONE.
- IDLE: when cpu_request_ready=1, latch the request and go to LOOKUP next edge.
- LOOKUP, read hit: data_out <= selected byte; go to DONE. Latency is 2 cycles from request to data_out_ready.
- LOOKUP, read miss, or any write: drive memory_request with the latched request, set memory_request_ready=1, go to MEM_WAIT. Writes always go to memory (write-through), hit or miss.
- MEM_WAIT: hold memory_request/memory_request_ready until memory_response_ready=1. On that edge:
  - Fill the line: data = memory_response, set valid, set tag.
  - Reads: data_out = the selected byte of the response.
  - Writes: data_out = wdata. The response already contains the written byte; the cache still merges wdata into the filled byte.
  - Drop memory_request_ready, go to DONE.
- DONE: data_out_ready=1 for as long as cpu_request_ready stays 1. Return to IDLE on the first cycle cpu_request_ready=0.
- data_out holds its value until the next completion.
- memory_response_ready is ignored outside MEM_WAIT.
- Snoop invalidate: when core X leaves MEM_WAIT on a write, the other core's line at the same index is cleared (valid=0) if valid and tag-matched.
- Simultaneous events:
  - If the other core fills the same line on the same edge, the invalidate wins and the line ends invalid.
  - If the other core is in MEM_WAIT for a read of that line, it still returns its response data but installs the line invalid.
  - Both cores writing the same line on the same edge: both copies end invalid.
- The two cores are otherwise fully independent; there is no shared arbitration inside the block.

Optional Feature:
- Macro WRITE_UPDATE_EN.
- Defined: a snooped write updates the matching byte in the other cache in place (write-update) instead of invalidating. The update lands on the same edge the writer completes. Against a same-edge fill, the update is applied after the fill.
- Undefined: write-invalidate as specified above.

Decomposition:
- Shared package holds:
  - Request field positions (WE_BIT=24, DATA_MSB=23, DATA_LSB=16, ADDR_MSB=15).
  - Widths: REQ_W=25, LINE_W=16, ADDR_W=16.
  - The FSM state enum.
  - A snoop bundle typedef {valid, we, addr, data}.
- One natural sub-module: l1_cache_ctrl, instantiated twice. It contains the FSM and tag/data arrays, exports a snoop-out bus and accepts a snoop-in bus. top_level only cross-wires the snoop buses.

Test Plan:
- Reset, then cpu0 write 16 to addr 23 -> memory_request_0=={1,16,23}. Respond 0x1000 -> data_out_0=16, data_out_ready_0=1.
- Then cpu1 write 25 to addr 23 -> cpu0 line invalidated. cpu0 read 23 -> miss, memory_request_0=={0,0,23}. Respond 0x1900 -> data_out_0=25.
- Repeat cpu0 read of 23 -> hit: no memory_request_ready_0, data_out_0=25 in 2 cycles.
- cpu1 read addr 22 after memory line 0xAB12 -> data_out_1=0x12. Read 23 -> hit, 0xAB.
- Conflict miss: cpu0 reads 0x0002 then 0x0022 (same index), then 0x0002 again -> third access misses.
- Assert reset low during MEM_WAIT -> outputs 0 immediately. Subsequent read of the same addr misses. With WRITE_UPDATE_EN, the first scenario's cpu0 read of 23 hits with 25.

Source files
------------

// File: rtl/top_level_pkg.sv
// ---------------------------------------------------------------------------
// top_level_pkg
// Shared definitions for the dual-core L1 data-cache subsystem.
//   - Field positions inside a 25-bit request word {we, wdata, addr}
//   - Bus widths for requests, cache lines and addresses
//   - Per-core controller FSM state enum
//   - Snoop bundle carried between the two cache controllers
//   - Byte select / byte merge helpers for the 2-byte line format
// ---------------------------------------------------------------------------
package top_level_pkg;

    localparam int WE_BIT   = 24;
    localparam int DATA_MSB = 23;
    localparam int DATA_LSB = 16;
    localparam int ADDR_MSB = 15;

    localparam int REQ_W  = 25;
    localparam int LINE_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_WAIT = 2'd2,
        DONE     = 2'd3
    } cache_state_e;

    // One write completion broadcast from a controller to its peer
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } snoop_t;

    // Byte 0 of a line lives in bits [7:0], byte 1 in bits [15:8]
    function automatic logic [7:0] selectByte(input logic [LINE_W-1:0] line,
                                              input logic              offset);
        return offset ? line[15:8] : line[7:0];
    endfunction

    function automatic logic [LINE_W-1:0] mergeByte(input logic [LINE_W-1:0] line,
                                                    input logic              offset,
                                                    input logic [7:0]        byteVal);
        logic [LINE_W-1:0] merged;
        merged = line;
        if (offset) begin
            merged[15:8] = byteVal;
        end else begin
            merged[7:0] = byteVal;
        end
        return merged;
    endfunction

endpackage

// File: rtl/top_level_l1_cache_ctrl.sv
// ---------------------------------------------------------------------------
// l1_cache_ctrl
// One private direct-mapped, write-through, write-allocate L1 data cache
// with its controller FSM (IDLE -> LOOKUP -> [MEM_WAIT] -> DONE).
//
// Ports:
//   clock               system clock, rising edge
//   reset               asynchronous, active-low reset
//   cpuRequest_i        {we, wdata, addr} from the CPU
//   cpuRequestReady_i   CPU request valid, held until dataOutReady_o seen
//   memResponse_i       aligned 2-byte line returned by memory
//   memResponseReady_i  memResponse_i valid (only honoured in MEM_WAIT)
//   snoopIn_i           write completions from the peer cache
//   dataOut_o           read data, or the written byte for writes
//   dataOutReady_o      request complete
//   memRequest_o        copy of the latched CPU request while in MEM_WAIT
//   memRequestReady_o   memory request valid
//   snoopOut_o          this cache's write completions, to the peer
//
// Build option: WRITE_UPDATE_EN
//   undefined - a peer write invalidates a matching line here
//   defined   - a peer write patches the matching byte here in place
// ---------------------------------------------------------------------------
module l1_cache_ctrl
    import top_level_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REQ_W-1:0]  cpuRequest_i,
    input  logic              cpuRequestReady_i,
    input  logic [LINE_W-1:0] memResponse_i,
    input  logic              memResponseReady_i,
    input  snoop_t            snoopIn_i,
    output logic [7:0]        dataOut_o,
    output logic              dataOutReady_o,
    output logic [REQ_W-1:0]  memRequest_o,
    output logic              memRequestReady_o,
    output snoop_t            snoopOut_o
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 1;

    cache_state_e      state_q, state_d;
    logic [REQ_W-1:0]  req_q, req_d;
    logic [7:0]        dataOut_q, dataOut_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    logic                  reqWe;
    logic [7:0]            reqData;
    logic [ADDR_W-1:0]     reqAddr;
    logic                  reqOffset;
    logic [INDEX_BITS-1:0] reqIndex;
    logic [TAG_W-1:0]      reqTag;

    logic                  lookupHit;
    logic                  fillEn;
    logic [LINE_W-1:0]     fillLine;

    logic [INDEX_BITS-1:0] snIndex;
    logic [TAG_W-1:0]      snTag;
    logic                  snoopHit;

    // Field decode of the latched request and of the incoming snoop
    always_comb begin
        reqWe     = req_q[WE_BIT];
        reqData   = req_q[DATA_MSB:DATA_LSB];
        reqAddr   = req_q[ADDR_MSB:0];
        reqOffset = reqAddr[0];
        reqIndex  = reqAddr[INDEX_BITS:1];
        reqTag    = reqAddr[ADDR_MSB:INDEX_BITS+1];
        snIndex   = snoopIn_i.addr[INDEX_BITS:1];
        snTag     = snoopIn_i.addr[ADDR_MSB:INDEX_BITS+1];
    end

    // Tag compare and line fill; a write folds wdata into the filled line
    // even though memory already returns the updated byte
    always_comb begin
        lookupHit = valid_q[reqIndex] && (tag_q[reqIndex] == reqTag);
        fillEn    = (state_q == MEM_WAIT) && memResponseReady_i;
        fillLine  = reqWe ? mergeByte(memResponse_i, reqOffset, reqData)
                          : memResponse_i;
    end

    // Snoop match is judged against the line as it will look after this
    // edge, so a same-edge fill of the snooped line is also caught
    always_comb begin
        snoopHit = 1'b0;
        if (snoopIn_i.valid && snoopIn_i.we) begin
            if (fillEn && (reqIndex == snIndex)) begin
                snoopHit = (reqTag == snTag);
            end else begin
                snoopHit = valid_q[snIndex] && (tag_q[snIndex] == snTag);
            end
        end
    end

`ifdef WRITE_UPDATE_EN
    logic [LINE_W-1:0] snoopLine;

    // Patched copy of the snooped line, built on top of any same-edge fill
    always_comb begin
        snoopLine = mergeByte((fillEn && (reqIndex == snIndex)) ? fillLine : data_q[snIndex],
                              snoopIn_i.addr[0], snoopIn_i.data);
    end
`else
    logic unusedSnoopData;

    // The peer's write data only matters in write-update builds
    assign unusedSnoopData = ^snoopIn_i.data;
`endif

    // Next-state logic for the per-core request sequencer
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        dataOut_d = dataOut_q;
        unique case (state_q)
            IDLE: begin
                if (cpuRequestReady_i) begin
                    req_d   = cpuRequest_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!reqWe && lookupHit) begin
                    dataOut_d = selectByte(data_q[reqIndex], reqOffset);
                    state_d   = DONE;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (memResponseReady_i) begin
                    dataOut_d = reqWe ? reqData : selectByte(memResponse_i, reqOffset);
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!cpuRequestReady_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            dataOut_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            dataOut_q <= dataOut_d;
        end
    end

    // Valid bits: the snoop update is ordered after the fill so an
    // invalidate always beats a fill of the same line
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            if (fillEn) begin
                valid_q[reqIndex] <= 1'b1;
            end
`ifndef WRITE_UPDATE_EN
            if (snoopHit) begin
                valid_q[snIndex] <= 1'b0;
            end
`endif
        end
    end

    // Tag and data storage; contents are meaningless while valid is clear
    always_ff @(posedge clock) begin
        if (fillEn) begin
            tag_q[reqIndex]  <= reqTag;
            data_q[reqIndex] <= fillLine;
        end
`ifdef WRITE_UPDATE_EN
        if (snoopHit) begin
            data_q[snIndex] <= snoopLine;
        end
`endif
    end

    // Memory side is presented straight from the state register; the
    // completion flag tracks the CPU handshake so it drops with the request
    always_comb begin
        memRequestReady_o = (state_q == MEM_WAIT);
        memRequest_o      = (state_q == MEM_WAIT) ? req_q : '0;
        dataOutReady_o    = (state_q == DONE) && cpuRequestReady_i;
        dataOut_o         = dataOut_q;
    end

    // A write announces itself to the peer on the edge it completes
    always_comb begin
        snoopOut_o       = '0;
        snoopOut_o.valid = fillEn && reqWe;
        snoopOut_o.we    = reqWe;
        snoopOut_o.addr  = reqAddr;
        snoopOut_o.data  = reqData;
    end

endmodule

// File: rtl/top_level.sv
// ---------------------------------------------------------------------------
// top_level
// Dual-core private L1 data-cache subsystem. Two identical l1_cache_ctrl
// instances, one per CPU port, each with its own memory channel. The only
// coupling between them is the cross-wired snoop bus that keeps the two
// caches coherent on writes.
//
// Ports (N = 0 or 1):
//   clock                      system clock, rising edge
//   reset                      asynchronous, active-low reset
//   cpu_request_N              {we[24], wdata[23:16], addr[15:0]}
//   cpu_request_ready_N        CPU request valid
//   memory_response_N          aligned line {byte addr|1, byte addr&~1}
//   memory_response_ready_N    memory_response_N valid
//   data_out_N                 read data or written byte
//   data_out_ready_N           request complete
//   memory_request_N           {we, wdata, addr} towards memory
//   memory_request_ready_N     memory request valid
//
// Build option: WRITE_UPDATE_EN selects write-update snooping instead of
// the default write-invalidate.
// ---------------------------------------------------------------------------
module top_level
    import top_level_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REQ_W-1:0]  cpu_request_0,
    input  logic              cpu_request_ready_0,
    input  logic [LINE_W-1:0] memory_response_0,
    input  logic              memory_response_ready_0,
    output logic [7:0]        data_out_0,
    output logic              data_out_ready_0,
    output logic [REQ_W-1:0]  memory_request_0,
    output logic              memory_request_ready_0,
    input  logic [REQ_W-1:0]  cpu_request_1,
    input  logic              cpu_request_ready_1,
    input  logic [LINE_W-1:0] memory_response_1,
    input  logic              memory_response_ready_1,
    output logic [7:0]        data_out_1,
    output logic              data_out_ready_1,
    output logic [REQ_W-1:0]  memory_request_1,
    output logic              memory_request_ready_1
);

    snoop_t snoopFrom0;
    snoop_t snoopFrom1;

    l1_cache_ctrl #(
        .INDEX_BITS (INDEX_BITS)
    ) u_cache0 (
        .clock              (clock),
        .reset              (reset),
        .cpuRequest_i       (cpu_request_0),
        .cpuRequestReady_i  (cpu_request_ready_0),
        .memResponse_i      (memory_response_0),
        .memResponseReady_i (memory_response_ready_0),
        .snoopIn_i          (snoopFrom1),
        .dataOut_o          (data_out_0),
        .dataOutReady_o     (data_out_ready_0),
        .memRequest_o       (memory_request_0),
        .memRequestReady_o  (memory_request_ready_0),
        .snoopOut_o         (snoopFrom0)
    );

    l1_cache_ctrl #(
        .INDEX_BITS (INDEX_BITS)
    ) u_cache1 (
        .clock              (clock),
        .reset              (reset),
        .cpuRequest_i       (cpu_request_1),
        .cpuRequestReady_i  (cpu_request_ready_1),
        .memResponse_i      (memory_response_1),
        .memResponseReady_i (memory_response_ready_1),
        .snoopIn_i          (snoopFrom0),
        .dataOut_o          (data_out_1),
        .dataOutReady_o     (data_out_ready_1),
        .memRequest_o       (memory_request_1),
        .memRequestReady_o  (memory_request_ready_1),
        .snoopOut_o         (snoopFrom1)
    );

endmodule

// File: tb/tb_top_level.sv
// ---------------------------------------------------------------------------
// tb_top_level
// Drives both CPU ports and plays the external memory. The reference model
// is a byte-addressed memory image plus, per core, which line address each
// cache index currently holds (-1 when nothing usable is held).
// ---------------------------------------------------------------------------
module tb_top_level;

    localparam int LINES = 16;

    logic        clock;
    logic        reset;
    logic [24:0] cpuReq       [2];
    logic        cpuReqReady  [2];
    logic [15:0] memResp      [2];
    logic        memRespReady [2];

    logic [7:0]  data_out_0, data_out_1;
    logic        data_out_ready_0, data_out_ready_1;
    logic [24:0] memory_request_0, memory_request_1;
    logic        memory_request_ready_0, memory_request_ready_1;

    logic [7:0]  mem [256];
    int          cachedLine [2][LINES];
    int          checkCount;
    int          errorCount;

    top_level #(.INDEX_BITS(4)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .cpu_request_0           (cpuReq[0]),
        .cpu_request_ready_0     (cpuReqReady[0]),
        .memory_response_0       (memResp[0]),
        .memory_response_ready_0 (memRespReady[0]),
        .data_out_0              (data_out_0),
        .data_out_ready_0        (data_out_ready_0),
        .memory_request_0        (memory_request_0),
        .memory_request_ready_0  (memory_request_ready_0),
        .cpu_request_1           (cpuReq[1]),
        .cpu_request_ready_1     (cpuReqReady[1]),
        .memory_response_1       (memResp[1]),
        .memory_response_ready_1 (memRespReady[1]),
        .data_out_1              (data_out_1),
        .data_out_ready_1        (data_out_ready_1),
        .memory_request_1        (memory_request_1),
        .memory_request_ready_1  (memory_request_ready_1)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something stalls outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] getDataOut(input int core);
        return (core == 0) ? data_out_0 : data_out_1;
    endfunction

    function automatic logic getDataOutReady(input int core);
        return (core == 0) ? data_out_ready_0 : data_out_ready_1;
    endfunction

    function automatic logic [24:0] getMemReq(input int core);
        return (core == 0) ? memory_request_0 : memory_request_1;
    endfunction

    function automatic logic getMemReqReady(input int core);
        return (core == 0) ? memory_request_ready_0 : memory_request_ready_1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < LINES; i++) begin
                cachedLine[c][i] = -1;
            end
        end
    endtask

    // After a completed access the core holds the line; a write leaves the
    // peer's copy stale unless write-update keeps it in step with memory
    task automatic modelComplete(input int core, input bit we, input logic [15:0] addr);
        int line;
        line = int'(addr[15:1]);
        cachedLine[core][line % LINES] = line;
`ifndef WRITE_UPDATE_EN
        if (we && cachedLine[1-core][line % LINES] == line) begin
            cachedLine[1-core][line % LINES] = -1;
        end
`endif
    endtask

    // One full CPU transaction on one port, with memory served from the model
    task automatic applyStimulus(input int core, input bit we, input logic [7:0] wdata,
                                 input logic [15:0] addr, input int delay,
                                 input bit updateModel);
        int line;
        int cyc;
        int d;
        bit expHit;
        bit sawMem;
        bit done;
        logic [7:0] expData;
        line   = int'(addr[15:1]);
        expHit = !we && (cachedLine[core][line % LINES] == line);
        if (we) begin
            mem[addr[7:0]] = wdata;
        end
        expData = mem[addr[7:0]];
        @(negedge clock);
        cpuReq[core]      = {we, wdata, addr};
        cpuReqReady[core] = 1'b1;
        cyc    = 0;
        sawMem = 1'b0;
        done   = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (getMemReqReady(core) && !sawMem) begin
                sawMem = 1'b1;
                checkOutput("memReqCycle", 32'(cyc), 32'd2);
                checkOutput("memReq", 32'(getMemReq(core)), 32'({we, wdata, addr}));
                d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
                for (int k = 0; k < d; k++) begin
                    @(negedge clock);
                    cyc++;
                    checkOutput("memReqHold", 32'(getMemReqReady(core)), 32'd1);
                end
                memResp[core]      = {mem[{addr[7:1], 1'b1}], mem[{addr[7:1], 1'b0}]};
                memRespReady[core] = 1'b1;
                @(negedge clock);
                cyc++;
                memRespReady[core] = 1'b0;
                memResp[core]      = $urandom();
            end
            if (getDataOutReady(core)) begin
                done = 1'b1;
            end
        end
        checkOutput("completed", 32'(done), 32'd1);
        checkOutput("memAccess", 32'(sawMem), 32'(!expHit));
        if (expHit) begin
            checkOutput("hitLatency", 32'(cyc), 32'd2);
        end
        checkOutput("dataOut", 32'(getDataOut(core)), 32'(expData));
        cpuReqReady[core] = 1'b0;
        #1;
        checkOutput("readyDrop", 32'(getDataOutReady(core)), 32'd0);
        if (updateModel) begin
            modelComplete(core, we, addr);
        end
    endtask

    initial begin
        int waitCnt;
        checkCount = 0;
        errorCount = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom());
        end
        mem[22] = 8'h00;
        mem[23] = 8'h00;
        clearModel();
        for (int c = 0; c < 2; c++) begin
            cpuReq[c]       = '0;
            cpuReqReady[c]  = 1'b0;
            memResp[c]      = '0;
            memRespReady[c] = 1'b0;
        end

        $display("[TB] reset state");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rstDataOut0", 32'(data_out_0), 32'd0);
        checkOutput("rstReady0", 32'(data_out_ready_0), 32'd0);
        checkOutput("rstMemReq0", 32'(memory_request_0), 32'd0);
        checkOutput("rstMemReqRdy0", 32'(memory_request_ready_0), 32'd0);
        checkOutput("rstDataOut1", 32'(data_out_1), 32'd0);
        checkOutput("rstMemReqRdy1", 32'(memory_request_ready_1), 32'd0);
        reset = 1'b1;

        $display("[TB] write, snoop, re-read");
        applyStimulus(0, 1'b1, 8'd16, 16'd23, 1, 1'b1);
        applyStimulus(1, 1'b1, 8'd25, 16'd23, 0, 1'b1);
        applyStimulus(0, 1'b0, 8'd0, 16'd23, 2, 1'b1);
        applyStimulus(0, 1'b0, 8'd0, 16'd23, -1, 1'b1);

        $display("[TB] conflict miss");
        applyStimulus(0, 1'b0, 8'd0, 16'h0002, -1, 1'b1);
        applyStimulus(0, 1'b0, 8'd0, 16'h0022, -1, 1'b1);
        applyStimulus(0, 1'b0, 8'd0, 16'h0002, -1, 1'b1);

        $display("[TB] reset during MEM_WAIT");
        @(negedge clock);
        cpuReq[0]      = {1'b0, 8'h00, 16'h003E};
        cpuReqReady[0] = 1'b1;
        waitCnt = 0;
        while (!memory_request_ready_0 && waitCnt < 20) begin
            @(negedge clock);
            waitCnt++;
        end
        checkOutput("rstReachMemWait", 32'(memory_request_ready_0), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midRstMemRdy", 32'(memory_request_ready_0), 32'd0);
        checkOutput("midRstMemReq", 32'(memory_request_0), 32'd0);
        checkOutput("midRstDataOut0", 32'(data_out_0), 32'd0);
        checkOutput("midRstDataOut1", 32'(data_out_1), 32'd0);
        checkOutput("midRstReady0", 32'(data_out_ready_0), 32'd0);
        cpuReqReady[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        clearModel();
        applyStimulus(0, 1'b0, 8'h00, 16'h003E, -1, 1'b1);

        $display("[TB] byte select from a filled line");
        mem[22] = 8'h12;
        mem[23] = 8'hAB;
        applyStimulus(1, 1'b0, 8'h00, 16'd22, -1, 1'b1);
        applyStimulus(1, 1'b0, 8'h00, 16'd23, -1, 1'b1);

        $display("[TB] same-edge writes to one line");
        fork
            applyStimulus(0, 1'b1, 8'h5A, 16'h0014, 1, 1'b0);
            applyStimulus(1, 1'b1, 8'hC3, 16'h0015, 1, 1'b0);
        join
`ifdef WRITE_UPDATE_EN
        cachedLine[0][10] = 10;
        cachedLine[1][10] = 10;
`else
        cachedLine[0][10] = -1;
        cachedLine[1][10] = -1;
`endif
        applyStimulus(0, 1'b0, 8'h00, 16'h0015, -1, 1'b1);
        applyStimulus(1, 1'b0, 8'h00, 16'h0014, -1, 1'b1);

        $display("[TB] read fill racing a peer write");
        fork
            applyStimulus(0, 1'b0, 8'h00, 16'h0018, 1, 1'b0);
            applyStimulus(1, 1'b1, 8'h77, 16'h0019, 1, 1'b0);
        join
        cachedLine[1][12] = 12;
`ifdef WRITE_UPDATE_EN
        cachedLine[0][12] = 12;
`else
        cachedLine[0][12] = -1;
`endif
        applyStimulus(0, 1'b0, 8'h00, 16'h0019, -1, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 150; n++) begin
            applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom()), 16'($urandom_range(0, 63)), -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
